// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared CPU datapath constants (data width, register index width, zero-register index)
package reg_file_pkg;
  localparam int CPU_DATA_W = 64;
  localparam int CPU_ADDR_W = 5;
  localparam int XZR_IDX = 31;
endpackage

// File: rtl/reg_file.sv
// reg_file: 32-entry register file, X31 reads as zero, two registered read ports with write bypass and stall, combinational debug port
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic              read_en,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [ADDR_W-1:0] dbg_reg,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(XZR_IDX);
  logic [DATA_W-1:0] regs [NREG];
  logic [ADDR_W-1:0] ra [2];
  logic we;
  assign we = reg_write && write_reg != XZR;
  assign ra[0] = read_reg1;
  assign ra[1] = read_reg2;
  always_ff @(posedge clk) begin
    if (reset)
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    else if (we)
      regs[write_reg] <= write_data;
  end
  genvar p;
  generate
    for (p = 0; p < 2; p++) begin : g_port
      logic [DATA_W-1:0] q;
      // bypass selects write_data into the capture register, so the path is register-to-register only
      always_ff @(posedge clk) begin
        if (reset)
          q <= '0;
        else if (read_en)
          q <= ra[p] == XZR ? '0 : (we && write_reg == ra[p]) ? write_data : regs[ra[p]];
      end
      if (p == 0) begin : g_o1
        assign read_data1 = q;
      end else begin : g_o2
        assign read_data2 = q;
      end
    end
  endgenerate
  assign dbg_data = dbg_reg == XZR ? '0 : regs[dbg_reg];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scoreboard bench for reg_file
module tb_reg_file;
  logic clk = 0;
  logic rst, en, we;
  logic [4:0] r1, r2, wa, dbg;
  logic [63:0] wd;
  logic [63:0] read_data1, read_data2, dbg_data;
  typedef struct {
    logic [63:0] e1;
    logic [63:0] e2;
  } exp_t;
  exp_t sb[$];
  logic [63:0] m [32];
  logic [63:0] h1, h2;
  int pass = 0;
  int total = 0;

  reg_file dut (
    .clk(clk), .reset(rst), .read_reg1(r1), .read_reg2(r2), .read_en(en),
    .reg_write(we), .write_reg(wa), .write_data(wd),
    .read_data1(read_data1), .read_data2(read_data2),
    .dbg_reg(dbg), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] rd_exp(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (we && wa == a && wa != 5'd31) return wd;
    return m[a];
  endfunction

  task automatic drive(input logic irst, input logic [4:0] ir1, input logic [4:0] ir2,
                       input logic ien, input logic iwe, input logic [4:0] iwa, input logic [63:0] iwd);
    exp_t e;
    rst = irst; r1 = ir1; r2 = ir2; en = ien; we = iwe; wa = iwa; wd = iwd;
    if (irst) begin
      h1 = 64'd0;
      h2 = 64'd0;
    end else if (ien) begin
      h1 = rd_exp(ir1);
      h2 = rd_exp(ir2);
    end
    e.e1 = h1;
    e.e2 = h2;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (rst) for (int i = 0; i < 32; i++) m[i] = 64'd0;
    else if (we && wa != 5'd31) m[wa] = wd;
    #1;
    e = sb.pop_front();
    chk("read_data1", read_data1, e.e1);
    chk("read_data2", read_data2, e.e2);
    rst = 0; en = 0; we = 0;
  endtask

  task automatic dbg_chk(input logic [4:0] idx, input logic [63:0] exp);
    dbg = idx;
    #1;
    chk($sformatf("dbg_data[%0d]", idx), dbg_data, exp);
  endtask

  initial begin
    rst = 0; en = 0; we = 0; r1 = 0; r2 = 0; wa = 0; wd = 0; dbg = 0;
    h1 = 0; h2 = 0;
    for (int i = 0; i < 32; i++) m[i] = 64'd0;
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 32; i++) dbg_chk(5'(i), 64'd0);
    drive(0, 0, 0, 0, 1, 5, 64'h0123456789ABCDEF);
    tick();
    drive(0, 5, 0, 1, 0, 0, 0);
    tick();
    chk("x5_read", read_data1, 64'h0123456789ABCDEF);
    drive(0, 0, 31, 1, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("xzr_read", read_data2, 64'd0);
    dbg_chk(31, 64'd0);
    drive(0, 0, 0, 0, 1, 7, 64'h10);
    tick();
    drive(0, 7, 7, 1, 1, 7, 64'h20);
    dbg_chk(7, 64'h10);
    tick();
    chk("bypass1", read_data1, 64'h20);
    chk("bypass2", read_data2, 64'h20);
    dbg_chk(7, 64'h20);
    drive(0, 7, 7, 0, 1, 7, 64'h30);
    tick();
    chk("stall_hold", read_data1, 64'h20);
    drive(0, 7, 0, 1, 0, 0, 0);
    tick();
    chk("stall_release", read_data1, 64'h30);
    drive(0, 3, 7, 1, 1, 3, 64'h55);
    tick();
    drive(1, 3, 7, 1, 1, 3, 64'h55);
    tick();
    chk("reset_out1", read_data1, 64'd0);
    for (int i = 0; i < 32; i++) dbg_chk(5'(i), 64'd0);
    drive(0, 3, 5, 1, 0, 0, 0);
    tick();
    chk("x3_after_reset", read_data1, 64'd0);
    for (int i = 0; i < 31; i++) begin
      drive(0, 0, 0, 0, 1, 5'(i), 64'(i * 32'h1111));
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      drive(0, 5'(i), 5'(31 - i), 1, 0, 0, 0);
      tick();
      chk("sweep1", read_data1, i == 31 ? 64'd0 : 64'(i * 32'h1111));
      chk("sweep2", read_data2, i == 0 ? 64'd0 : 64'((31 - i) * 32'h1111));
    end
    drive(0, 9, 9, 1, 1, 9, 64'hDEAD_BEEF_0000_0009);
    tick();
    chk("final_bypass", read_data2, 64'hDEAD_BEEF_0000_0009);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
